// File: rtl/axi_node_pkg.sv
// Shared types and helpers for the AXI node arbiters.
package axi_node_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } arb_state_t;

   // Wraps at n rather than at a power of two, so non-power-of-2 source counts stay in range.
   function automatic int unsigned rr_wrap_inc(input int unsigned idx, input int unsigned n);
      if (idx + 32'd1 >= n) begin
         return 32'd0;
      end else begin
         return idx + 32'd1;
      end
   endfunction

endpackage

// File: rtl/axi_rr_burst_arbiter_chk.sv
// Property checker for the burst arbiter outputs.
module axi_rr_burst_arbiter_chk #(
   parameter int N_IN      = 16,
   parameter int SEL_WIDTH = $clog2(N_IN)
) (
   input logic                 clk,
   input logic                 rst,
   input logic [N_IN-1:0]      in_ready,
   input logic [N_IN-1:0]      gnt_onehot,
   input logic [SEL_WIDTH-1:0] SEL,
   input logic                 out_valid,
   input logic                 out_ready
);

   a_ready_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(in_ready));
   a_gnt_onehot0:   assert property (@(posedge clk) disable iff (rst) $onehot0(gnt_onehot));
   a_sel_range:     assert property (@(posedge clk) disable iff (rst) 32'(SEL) < N_IN);
   a_sel_stable:    assert property (@(posedge clk) disable iff (rst)
                                     (out_valid && !out_ready) |=> $stable(SEL));

endmodule

// File: rtl/axi_rr_pick.sv
// Round-robin picker: first asserted valid at or after rr_ptr+1, wrapping at N_IN.
module axi_rr_pick #(
   parameter int N_IN      = 16,
   parameter int SEL_WIDTH = $clog2(N_IN)
) (
   input  logic [N_IN-1:0]      in_valid,
   input  logic [SEL_WIDTH-1:0] rr_ptr,
   output logic [SEL_WIDTH-1:0] pick_idx,
   output logic                 pick_vld
);
   import axi_node_pkg::*;

   int unsigned idx_s;

   // Ascending search from the slot after the last winner
   always_comb begin
      pick_idx = '0;
      pick_vld = 1'b0;
      idx_s    = rr_wrap_inc(32'(rr_ptr), 32'(N_IN));
      for (int k = 0; k < N_IN; k++) begin
         if (!pick_vld && in_valid[SEL_WIDTH'(idx_s)]) begin
            pick_idx = SEL_WIDTH'(idx_s);
            pick_vld = 1'b1;
         end else begin
            pick_vld = pick_vld;
         end
         idx_s = rr_wrap_inc(idx_s, 32'(N_IN));
      end
   end

endmodule

// File: rtl/axi_rr_burst_arbiter.sv
// Round-robin arbiter ahead of the N_IN:1 AXI data mux; holds the grant across a burst
// until the last-beat handshake so a granted valid is never switched away.
module axi_rr_burst_arbiter #(
   parameter int N_IN       = 16,
   parameter int SEL_WIDTH  = $clog2(N_IN),
   parameter int LOCK_BURST = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N_IN-1:0]      in_valid,
   input  logic [N_IN-1:0]      in_last,
   output logic [N_IN-1:0]      in_ready,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [SEL_WIDTH-1:0] SEL,
   output logic [N_IN-1:0]      gnt_onehot
);
   import axi_node_pkg::*;

   localparam logic [SEL_WIDTH-1:0] PTR_RST = SEL_WIDTH'(N_IN - 1);

   arb_state_t           state_q, state_d;
   logic [SEL_WIDTH-1:0] sel_q, sel_d, rr_ptr_q, rr_ptr_d;
   logic [SEL_WIDTH-1:0] pick_idx, sel_s;
   logic                 pick_vld, out_valid_s, hs_s, last_eff_s;
   logic [N_IN-1:0]      in_ready_s, gnt_s;

   axi_rr_pick #(
      .N_IN      (N_IN),
      .SEL_WIDTH (SEL_WIDTH)
   ) u_pick (
      .in_valid (in_valid),
      .rr_ptr   (rr_ptr_q),
      .pick_idx (pick_idx),
      .pick_vld (pick_vld)
   );

   // Grant steering, handshake detection and next state
   always_comb begin
      state_d     = state_q;
      sel_d       = sel_q;
      rr_ptr_d    = rr_ptr_q;
      sel_s       = sel_q;
      out_valid_s = 1'b0;
      in_ready_s  = '0;
      gnt_s       = '0;
      case (state_q)
         IDLE: begin
            if (pick_vld) begin
               sel_s                = pick_idx;
               out_valid_s          = 1'b1;
               in_ready_s[pick_idx] = out_ready;
               gnt_s[pick_idx]      = 1'b1;
            end else begin
               sel_s = sel_q;
            end
         end
         LOCKED: begin
            out_valid_s       = in_valid[sel_q];
            in_ready_s[sel_q] = out_ready;
            gnt_s[sel_q]      = 1'b1;
         end
         default: begin
            out_valid_s = 1'b0;
         end
      endcase

      hs_s       = out_valid_s & out_ready;
      last_eff_s = (LOCK_BURST != 0) ? in_last[sel_s] : 1'b1;

      // A stall in IDLE locks too, so the pending valid keeps its grant.
      case (state_q)
         IDLE: begin
            if (hs_s && last_eff_s) begin
               rr_ptr_d = pick_idx;
            end else if (out_valid_s) begin
               state_d = LOCKED;
               sel_d   = pick_idx;
            end else begin
               state_d = IDLE;
            end
         end
         LOCKED: begin
            if (hs_s && last_eff_s) begin
               state_d  = IDLE;
               rr_ptr_d = sel_q;
            end else begin
               state_d = LOCKED;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Outputs are held quiet for as long as reset is asserted
   always_comb begin
      if (rst) begin
         SEL        = '0;
         out_valid  = 1'b0;
         in_ready   = '0;
         gnt_onehot = '0;
      end else begin
         SEL        = sel_s;
         out_valid  = out_valid_s;
         in_ready   = in_ready_s;
         gnt_onehot = gnt_s;
      end
   end

   // State, held select and round-robin pointer
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         sel_q    <= '0;
         rr_ptr_q <= PTR_RST;
      end else begin
         state_q  <= state_d;
         sel_q    <= sel_d;
         rr_ptr_q <= rr_ptr_d;
      end
   end

   axi_rr_burst_arbiter_chk #(
      .N_IN      (N_IN),
      .SEL_WIDTH (SEL_WIDTH)
   ) u_chk (
      .clk        (clk),
      .rst        (rst),
      .in_ready   (in_ready),
      .gnt_onehot (gnt_onehot),
      .SEL        (SEL),
      .out_valid  (out_valid),
      .out_ready  (out_ready)
   );

endmodule

// File: tb/tb_axi_rr_burst_arbiter.sv
// Scoreboard bench: three arbiter instances (N=4 burst, N=5 burst, N=4 per-beat).
module tb_axi_rr_burst_arbiter;

   logic clk = 1'b0;
   logic rst;

   logic [3:0] a_valid, a_last, a_ready, a_gnt;
   logic       a_ovalid, a_oready;
   logic [1:0] a_sel;
   logic [4:0] b_valid, b_last, b_ready, b_gnt;
   logic       b_ovalid, b_oready;
   logic [2:0] b_sel;
   logic [3:0] c_valid, c_last, c_ready, c_gnt;
   logic       c_ovalid, c_oready;
   logic [1:0] c_sel;

   logic [10:0] a_obs, c_obs;
   logic [13:0] b_obs;

   // {rst, in_valid, in_last, out_ready, expected {SEL, out_valid, in_ready, gnt_onehot}}
   typedef struct packed {
      logic        rs;
      logic [3:0]  v;
      logic [3:0]  lst;
      logic        ordy;
      logic [10:0] want;
   } row4_t;

   typedef struct packed {
      logic        rs;
      logic [4:0]  v;
      logic [4:0]  lst;
      logic        ordy;
      logic [13:0] want;
   } row5_t;

   logic [10:0] sb4[$];
   logic [13:0] sb5[$];
   int n_vec  = 0;
   int n_miss = 0;

   always #5 clk = ~clk;

   axi_rr_burst_arbiter #(.N_IN(4), .LOCK_BURST(1)) u_a (
      .clk(clk), .rst(rst), .in_valid(a_valid), .in_last(a_last), .in_ready(a_ready),
      .out_valid(a_ovalid), .out_ready(a_oready), .SEL(a_sel), .gnt_onehot(a_gnt));

   axi_rr_burst_arbiter #(.N_IN(5), .LOCK_BURST(1)) u_b (
      .clk(clk), .rst(rst), .in_valid(b_valid), .in_last(b_last), .in_ready(b_ready),
      .out_valid(b_ovalid), .out_ready(b_oready), .SEL(b_sel), .gnt_onehot(b_gnt));

   axi_rr_burst_arbiter #(.N_IN(4), .LOCK_BURST(0)) u_c (
      .clk(clk), .rst(rst), .in_valid(c_valid), .in_last(c_last), .in_ready(c_ready),
      .out_valid(c_ovalid), .out_ready(c_oready), .SEL(c_sel), .gnt_onehot(c_gnt));

   assign a_obs = {a_sel, a_ovalid, a_ready, a_gnt};
   assign b_obs = {b_sel, b_ovalid, b_ready, b_gnt};
   assign c_obs = {c_sel, c_ovalid, c_ready, c_gnt};

   function automatic row4_t r4(input logic rs, input logic [3:0] v, input logic [3:0] lst,
                                input logic ordy, input logic [1:0] sel, input logic ov,
                                input logic [3:0] rdy, input logic [3:0] gnt);
      return {rs, v, lst, ordy, sel, ov, rdy, gnt};
   endfunction

   function automatic row5_t r5(input logic rs, input logic [4:0] v, input logic [4:0] lst,
                                input logic ordy, input logic [2:0] sel, input logic ov,
                                input logic [4:0] rdy, input logic [4:0] gnt);
      return {rs, v, lst, ordy, sel, ov, rdy, gnt};
   endfunction

   task automatic drive_a(input row4_t r);
      rst = r.rs; a_valid = r.v; a_last = r.lst; a_oready = r.ordy;
      sb4.push_back(r.want);
   endtask

   task automatic drive_c(input row4_t r);
      rst = r.rs; c_valid = r.v; c_last = r.lst; c_oready = r.ordy;
      sb4.push_back(r.want);
   endtask

   task automatic drive_b(input row5_t r);
      rst = r.rs; b_valid = r.v; b_last = r.lst; b_oready = r.ordy;
      sb5.push_back(r.want);
   endtask

   task automatic test_reset();
      row4_t rows[$];
      logic [10:0] want;
      rows.push_back(r4(1'b1, 4'b1111, 4'b1111, 1'b1, 2'd0, 1'b0, 4'b0000, 4'b0000));
      rows.push_back(r4(1'b0, 4'b0000, 4'b1111, 1'b1, 2'd0, 1'b0, 4'b0000, 4'b0000));
      foreach (rows[i]) begin
         drive_a(rows[i]);
         @(negedge clk);
         want = sb4.pop_front();
         n_vec++;
         if (a_obs !== want) begin
            n_miss++;
            $display("FAIL reset[%0d]: {sel,ov,rdy,gnt} got %b required %b", i, a_obs, want);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_rotation();
      logic [10:0] want;
      for (int i = 0; i < 5; i++) begin
         logic [1:0] s;
         logic [3:0] g;
         s = 2'(i % 4);
         g = 4'b0001 << s;
         drive_a(r4(1'b0, 4'b1111, 4'b1111, 1'b1, s, 1'b1, g, g));
         @(negedge clk);
         want = sb4.pop_front();
         n_vec++;
         if (a_obs !== want) begin
            n_miss++;
            $display("FAIL rotation[%0d]: {sel,ov,rdy,gnt} got %b required %b", i, a_obs, want);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_burst();
      row4_t rows[$];
      logic [10:0] want;
      rows.push_back(r4(1'b0, 4'b0010, 4'b1111, 1'b1, 2'd1, 1'b1, 4'b0010, 4'b0010));
      rows.push_back(r4(1'b0, 4'b0110, 4'b1011, 1'b1, 2'd2, 1'b1, 4'b0100, 4'b0100));
      rows.push_back(r4(1'b0, 4'b0110, 4'b1011, 1'b1, 2'd2, 1'b1, 4'b0100, 4'b0100));
      rows.push_back(r4(1'b0, 4'b0010, 4'b1011, 1'b1, 2'd2, 1'b0, 4'b0100, 4'b0100));
      rows.push_back(r4(1'b0, 4'b0110, 4'b1011, 1'b1, 2'd2, 1'b1, 4'b0100, 4'b0100));
      rows.push_back(r4(1'b0, 4'b0110, 4'b1111, 1'b1, 2'd2, 1'b1, 4'b0100, 4'b0100));
      rows.push_back(r4(1'b0, 4'b0010, 4'b1111, 1'b1, 2'd1, 1'b1, 4'b0010, 4'b0010));
      foreach (rows[i]) begin
         drive_a(rows[i]);
         @(negedge clk);
         want = sb4.pop_front();
         n_vec++;
         if (a_obs !== want) begin
            n_miss++;
            $display("FAIL burst[%0d]: {sel,ov,rdy,gnt} got %b required %b", i, a_obs, want);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_stall();
      row4_t rows[$];
      logic [10:0] want;
      rows.push_back(r4(1'b1, 4'b0000, 4'b1111, 1'b0, 2'd0, 1'b0, 4'b0000, 4'b0000));
      rows.push_back(r4(1'b0, 4'b0001, 4'b1111, 1'b0, 2'd0, 1'b1, 4'b0000, 4'b0001));
      for (int k = 0; k < 4; k++)
         rows.push_back(r4(1'b0, 4'b1001, 4'b1111, 1'b0, 2'd0, 1'b1, 4'b0000, 4'b0001));
      rows.push_back(r4(1'b0, 4'b1001, 4'b1111, 1'b1, 2'd0, 1'b1, 4'b0001, 4'b0001));
      rows.push_back(r4(1'b0, 4'b1000, 4'b1111, 1'b1, 2'd3, 1'b1, 4'b1000, 4'b1000));
      rows.push_back(r4(1'b0, 4'b1000, 4'b1111, 1'b1, 2'd3, 1'b1, 4'b1000, 4'b1000));
      foreach (rows[i]) begin
         drive_a(rows[i]);
         @(negedge clk);
         want = sb4.pop_front();
         n_vec++;
         if (a_obs !== want) begin
            n_miss++;
            $display("FAIL stall[%0d]: {sel,ov,rdy,gnt} got %b required %b", i, a_obs, want);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_async_reset();
      row4_t rows[$];
      logic [10:0] want;
      rows.push_back(r4(1'b0, 4'b1000, 4'b0000, 1'b1, 2'd3, 1'b1, 4'b1000, 4'b1000));
      rows.push_back(r4(1'b1, 4'b1000, 4'b0000, 1'b1, 2'd0, 1'b0, 4'b0000, 4'b0000));
      rows.push_back(r4(1'b0, 4'b1001, 4'b1111, 1'b1, 2'd0, 1'b1, 4'b0001, 4'b0001));
      rows.push_back(r4(1'b0, 4'b1001, 4'b1111, 1'b1, 2'd3, 1'b1, 4'b1000, 4'b1000));
      foreach (rows[i]) begin
         drive_a(rows[i]);
         @(negedge clk);
         want = sb4.pop_front();
         n_vec++;
         if (a_obs !== want) begin
            n_miss++;
            $display("FAIL async_reset[%0d]: {sel,ov,rdy,gnt} got %b required %b", i, a_obs, want);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_wrap5();
      row5_t rows[$];
      logic [13:0] want;
      rows.push_back(r5(1'b1, 5'b10001, 5'b11111, 1'b1, 3'd0, 1'b0, 5'b00000, 5'b00000));
      rows.push_back(r5(1'b0, 5'b10001, 5'b11111, 1'b1, 3'd0, 1'b1, 5'b00001, 5'b00001));
      rows.push_back(r5(1'b0, 5'b10001, 5'b11111, 1'b1, 3'd4, 1'b1, 5'b10000, 5'b10000));
      rows.push_back(r5(1'b0, 5'b10001, 5'b11111, 1'b1, 3'd0, 1'b1, 5'b00001, 5'b00001));
      rows.push_back(r5(1'b0, 5'b10000, 5'b11111, 1'b1, 3'd4, 1'b1, 5'b10000, 5'b10000));
      rows.push_back(r5(1'b0, 5'b00010, 5'b11111, 1'b1, 3'd1, 1'b1, 5'b00010, 5'b00010));
      foreach (rows[i]) begin
         drive_b(rows[i]);
         @(negedge clk);
         want = sb5.pop_front();
         n_vec++;
         if (b_obs !== want) begin
            n_miss++;
            $display("FAIL wrap5[%0d]: {sel,ov,rdy,gnt} got %b required %b", i, b_obs, want);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_no_lock();
      row4_t rows[$];
      logic [10:0] want;
      rows.push_back(r4(1'b1, 4'b0110, 4'b0000, 1'b1, 2'd0, 1'b0, 4'b0000, 4'b0000));
      rows.push_back(r4(1'b0, 4'b0110, 4'b0000, 1'b1, 2'd1, 1'b1, 4'b0010, 4'b0010));
      rows.push_back(r4(1'b0, 4'b0110, 4'b0000, 1'b1, 2'd2, 1'b1, 4'b0100, 4'b0100));
      rows.push_back(r4(1'b0, 4'b0110, 4'b0000, 1'b1, 2'd1, 1'b1, 4'b0010, 4'b0010));
      rows.push_back(r4(1'b0, 4'b0110, 4'b0000, 1'b0, 2'd2, 1'b1, 4'b0000, 4'b0100));
      rows.push_back(r4(1'b0, 4'b0110, 4'b0000, 1'b0, 2'd2, 1'b1, 4'b0000, 4'b0100));
      rows.push_back(r4(1'b0, 4'b0110, 4'b0000, 1'b1, 2'd2, 1'b1, 4'b0100, 4'b0100));
      rows.push_back(r4(1'b0, 4'b0110, 4'b0000, 1'b1, 2'd1, 1'b1, 4'b0010, 4'b0010));
      foreach (rows[i]) begin
         drive_c(rows[i]);
         @(negedge clk);
         want = sb4.pop_front();
         n_vec++;
         if (c_obs !== want) begin
            n_miss++;
            $display("FAIL no_lock[%0d]: {sel,ov,rdy,gnt} got %b required %b", i, c_obs, want);
         end
         @(posedge clk); #1;
      end
   endtask

   initial begin
      rst = 1'b1;
      a_valid = '0; a_last = '0; a_oready = 1'b0;
      b_valid = '0; b_last = '0; b_oready = 1'b0;
      c_valid = '0; c_last = '0; c_oready = 1'b0;
      @(posedge clk); #1;
      test_reset();
      test_rotation();
      test_burst();
      test_stall();
      test_async_reset();
      test_wrap5();
      test_no_lock();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
